// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants (receive FSM encoding, baud divisors)
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // 38400 baud at 50 MHz: full-bit period and mid-bit offset used by speed_select
    localparam int BPS_PERIOD = 1301;
    localparam int BPS_HALF   = 650;

endpackage

// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - received-byte output bundle of uart_rx_frame
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;

    modport master (output rx_data, output rx_valid, output frame_err, output parity_err);
    modport slave  (input  rx_data, input  rx_valid, input  frame_err, input  parity_err);
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - serial line synchronizer chain plus falling-edge detector
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rs232_rx,
    output logic line,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Flops preset to 1 so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rs232_rx};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign line = sync_q[SYNC_STAGES-1];
    assign fall = hist_q & ~line;
endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receive framer driven by speed_select mid-bit ticks
// Optional even parity bit compiled in with `define UART_RX_PARITY_EN.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rs232_rx,
    input  logic              clk_bps,
    output logic              bps_start,
    output logic              rx_busy,
    uart_rx_frame_if.master   rx
);
    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 bps_q;
    logic                 line;
    logic                 fall;
`ifdef UART_RX_PARITY_EN
    logic                 parity_ok;
    logic                 perr_q;
`endif

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs232_rx (rs232_rx),
        .line     (line),
        .fall     (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            bps_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_ok <= 1'b1;
            perr_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: if (fall) begin
                    state <= ST_START;
                    bps_q <= 1'b1;
                end
                // A line already back high at mid start bit was only a glitch
                ST_START: if (clk_bps) begin
                    if (line) begin
                        state <= ST_IDLE;
                        bps_q <= 1'b0;
                    end else begin
                        cnt   <= '0;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: if (clk_bps) begin
                    shift <= {line, shift[DATA_BITS-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state <= ST_PARITY;
`else
                        state <= ST_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: if (clk_bps) begin
                    parity_ok <= (line == ^shift);
                    state     <= ST_STOP;
                end
`endif
                ST_STOP: if (clk_bps) begin
                    bps_q <= 1'b0;
                    if (line) begin
                        state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (parity_ok) begin
                            data_q  <= shift;
                            valid_q <= 1'b1;
                        end else begin
                            perr_q  <= 1'b1;
                        end
`else
                        data_q  <= shift;
                        valid_q <= 1'b1;
`endif
                    end else begin
                        ferr_q <= 1'b1;
                        state  <= ST_BREAK;
                    end
                end
                ST_BREAK: if (line) begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    bps_q <= 1'b0;
                end
            endcase
        end
    end

    assign bps_start     = bps_q;
    assign rx_busy       = (state != ST_IDLE);
    assign rx.rx_data    = data_q;
    assign rx.rx_valid   = valid_q;
    assign rx.frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err = perr_q;
`else
    assign rx.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - self-checking bench for uart_rx_frame with a scaled speed_select model
module tb_uart_rx_frame;
    localparam int PERIOD = 32;
    localparam int HALF   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rs232_rx = 1'b1;
    logic clk_bps = 1'b0;
    logic bps_start;
    logic rx_busy;

    uart_rx_frame_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_frame #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs232_rx  (rs232_rx),
        .clk_bps   (clk_bps),
        .bps_start (bps_start),
        .rx_busy   (rx_busy),
        .rx        (rx_if)
    );

    always #5 clk = ~clk;

    // Scaled speed_select: counter cleared while bps_start low, tick at mid-bit
    int bps_cnt = 0;
    always @(negedge clk) begin
        clk_bps = 1'b0;
        if (!bps_start) begin
            bps_cnt = 0;
        end else begin
            if (bps_cnt == HALF) clk_bps = 1'b1;
            bps_cnt = (bps_cnt == PERIOD - 1) ? 0 : bps_cnt + 1;
        end
    end

    int n_valid = 0;
    int n_ferr  = 0;
    int n_perr  = 0;
    logic [7:0] last_data = 8'h00;
    always @(negedge clk) begin
        if (rx_if.rx_valid) begin
            n_valid++;
            last_data = rx_if.rx_data;
        end
        if (rx_if.frame_err)  n_ferr++;
        if (rx_if.parity_err) n_perr++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bit_out(input logic v, input int nbits);
        rs232_rx = v;
        repeat (nbits * PERIOD) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip,
                              input int hold_bits, input int gap_bits);
        bit_out(1'b0, 1);
        for (int i = 0; i < 8; i++) bit_out(d[i], 1);
`ifdef UART_RX_PARITY_EN
        bit_out((^d) ^ pflip, 1);
`endif
        bit_out(stop, 1);
        if (hold_bits > 0) begin
            bit_out(1'b0, hold_bits);
            check("busy_in_break", rx_busy, 1);
        end
        bit_out(1'b1, gap_bits);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pflip;
        int         hold_bits;
        int         gap_bits;
        int         exp_v;
        int         exp_f;
        int         exp_p;
        logic [7:0] exp_data;
    } vec_t;

`ifdef UART_RX_PARITY_EN
    localparam int NV = 8;
`else
    localparam int NV = 6;
`endif
    vec_t vec [NV];

    initial begin
        int v0, f0, p0;

        vec[0] = '{8'hA5, 1'b1, 1'b0, 0, 1, 1, 0, 0, 8'hA5};
        vec[1] = '{8'h3C, 1'b0, 1'b0, 3, 1, 0, 1, 0, 8'hA5};
        vec[2] = '{8'h55, 1'b1, 1'b0, 0, 1, 1, 0, 0, 8'h55};
        vec[3] = '{8'h00, 1'b1, 1'b0, 0, 1, 1, 0, 0, 8'h00};
        vec[4] = '{8'hFF, 1'b1, 1'b0, 0, 1, 1, 0, 0, 8'hFF};
        vec[5] = '{8'h81, 1'b1, 1'b0, 0, 1, 1, 0, 0, 8'h81};
`ifdef UART_RX_PARITY_EN
        vec[6] = '{8'h07, 1'b1, 1'b1, 0, 1, 0, 0, 1, 8'h81};
        vec[7] = '{8'h07, 1'b1, 1'b0, 0, 1, 1, 0, 0, 8'h07};
`endif

        repeat (3) @(negedge clk);
        check("rst_bps_start", bps_start, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_rx_data", rx_if.rx_data, 0);
        check("rst_strobes", {rx_if.rx_valid, rx_if.frame_err, rx_if.parity_err}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_bps_start", bps_start, 0);

        // Start-edge latency: fall to bps_start is sync stages + 1 clocks
        rs232_rx = 1'b0;
        @(negedge clk); check("lat_clk1", bps_start, 0);
        @(negedge clk); check("lat_clk2", bps_start, 0);
        @(negedge clk); check("lat_clk3", bps_start, 1);
        @(negedge clk); // 4 clocks low in total: a glitch
        rs232_rx = 1'b1;
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        repeat (2 * PERIOD) @(negedge clk);
        check("glitch_strobes", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
        check("glitch_bps_start", bps_start, 0);
        check("glitch_busy", rx_busy, 0);
        check("glitch_rx_data", rx_if.rx_data, 0);

        for (int i = 0; i < NV; i++) begin
            v0 = n_valid; f0 = n_ferr; p0 = n_perr;
            send_frame(vec[i].data, vec[i].stop, vec[i].pflip, vec[i].hold_bits, vec[i].gap_bits);
            check($sformatf("v%0d_valid", i), n_valid - v0, vec[i].exp_v);
            check($sformatf("v%0d_ferr", i), n_ferr - f0, vec[i].exp_f);
            check($sformatf("v%0d_perr", i), n_perr - p0, vec[i].exp_p);
            check($sformatf("v%0d_data", i), rx_if.rx_data, vec[i].exp_data);
            check($sformatf("v%0d_bps_low", i), bps_start, 0);
            if (vec[i].exp_v == 1) check($sformatf("v%0d_strobe_data", i), last_data, vec[i].exp_data);
        end

        // Reset in the middle of data bit 4 of 0x5A
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        bit_out(1'b0, 1);
        for (int i = 0; i < 4; i++) bit_out(((8'h5A >> i) & 8'h01) != 0, 1);
        rs232_rx = 1'b1;
        repeat (HALF) @(negedge clk);
        check("pre_rst_busy", rx_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_bps_start", bps_start, 0);
        check("mid_rst_busy", rx_busy, 0);
        check("mid_rst_rx_data", rx_if.rx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * PERIOD) @(negedge clk);
        check("mid_rst_no_strobe", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
        send_frame(8'h5A, 1'b1, 1'b0, 0, 1);
        check("after_rst_valid", n_valid - v0, 1);
        check("after_rst_data", rx_if.rx_data, 8'h5A);
        check("after_rst_errs", (n_ferr - f0) + (n_perr - p0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
